// File: rtl/sw_debouncer.sv
// rtl/sw_debouncer.sv - multi-channel slide-switch synchronizer and debouncer
// Each channel: 2-flop sync, 4-state qualify FSM, registered level/edge/busy outputs.
module sw_debouncer #(
  parameter int N         = 4,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] sw_db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] busy
);

  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    WAIT1   = 2'd1,
    STABLE1 = 2'd2,
    WAIT0   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N-1:0]     s1_q, s2_q;
  state_t           state_q [N];
  state_t           state_d [N];
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     db_q, db_d;
  logic [N-1:0]     rise_q, rise_d;
  logic [N-1:0]     fall_q, fall_d;
  logic [N-1:0]     busy_q, busy_d;

  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    busy_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE0: begin
          if (s2_q[i]) begin
            state_d[i] = WAIT1;
            cnt_d[i]   = '0;
          end
        end
        WAIT1: begin
          if (!s2_q[i]) begin
            state_d[i] = STABLE0;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = STABLE1;
            cnt_d[i]   = '0;
            db_d[i]    = 1'b1;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        STABLE1: begin
          if (!s2_q[i]) begin
            state_d[i] = WAIT0;
            cnt_d[i]   = '0;
          end
        end
        WAIT0: begin
          if (s2_q[i]) begin
            state_d[i] = STABLE1;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = STABLE0;
            cnt_d[i]   = '0;
            db_d[i]    = 1'b0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = STABLE0;
          cnt_d[i]   = '0;
        end
      endcase
      // busy is derived from the next state so the registered copy always agrees with state_q
      busy_d[i] = (state_d[i] == WAIT1) || (state_d[i] == WAIT0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      busy_q <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= STABLE0;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q   <= sw_in;
      s2_q   <= s1_q;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      busy_q <= busy_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign sw_db = db_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;

endmodule
